// File: rtl/fetch_stage.sv
// Instruction fetch stage: credit-limited sequential fetch into an in-order queue,
// with redirect flush and stale-response discard. Optional macro: FETCH_BYPASS_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_valid_F,
  output logic [31:0] o_pc_F,
  output logic [31:0] o_pc_four_F,
  output logic [31:0] o_instr_F
);
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int PW = $clog2(QDEPTH);
  localparam logic [CW:0] QD = QDEPTH[CW:0];

  logic [31:0]              r_fetch_pc, r_deliver_pc;
  logic [QDEPTH-1:0][31:0]  r_q;
  logic [PW-1:0]            r_rd, r_wr;
  logic [CW-1:0]            r_count, r_inflight, r_discard;

  logic [31:0]   w_tgt, w_head;
  logic [CW:0]   w_used;
  logic          w_req, w_issue, w_resp, w_accept, w_byp;
  logic          w_valid, w_pop, w_pop_q, w_push;
  logic [CW-1:0] w_inflight_nxt, w_count_nxt;

  assign w_tgt    = i_redirect_pc & ~32'h3;
  assign w_head   = r_q[r_rd];
  assign w_used   = {1'b0, r_inflight} + {1'b0, r_count};
  assign w_req    = !i_rst && !i_redirect && (w_used < QD);
  assign w_issue  = w_req && i_imem_gnt;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign w_resp   = i_imem_rvalid && (r_inflight != '0);
  assign w_accept = w_resp && (r_discard == '0) && !i_redirect;

`ifdef FETCH_BYPASS_EN
  assign w_byp = w_accept && (r_count == '0);
`else
  assign w_byp = 1'b0;
`endif

  assign w_valid = !i_redirect && ((r_count != '0) || w_byp);
  assign w_pop   = w_valid && !i_stall;
  assign w_pop_q = w_pop && (r_count != '0);
  // A bypassed response consumed this cycle never enters the queue.
  assign w_push  = w_accept && !(w_byp && !i_stall);

  assign w_inflight_nxt = r_inflight + CW'(w_issue) - CW'(w_resp);
  assign w_count_nxt    = r_count + CW'(w_push) - CW'(w_pop_q);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fetch_pc   <= RESET_PC;
      r_deliver_pc <= RESET_PC;
      r_rd         <= '0;
      r_wr         <= '0;
      r_count      <= '0;
      r_inflight   <= '0;
      r_discard    <= '0;
    end else if (i_redirect) begin
      // Everything still outstanding after this cycle belongs to the old path.
      r_fetch_pc   <= w_tgt;
      r_deliver_pc <= w_tgt;
      r_rd         <= '0;
      r_wr         <= '0;
      r_count      <= '0;
      r_inflight   <= w_inflight_nxt;
      r_discard    <= w_inflight_nxt;
    end else begin
      if (w_issue) r_fetch_pc   <= r_fetch_pc + 32'd4;
      if (w_pop)   r_deliver_pc <= r_deliver_pc + 32'd4;
      if (w_push)  r_wr         <= r_wr + 1'b1;
      if (w_pop_q) r_rd         <= r_rd + 1'b1;
      if (w_resp && (r_discard != '0)) r_discard <= r_discard - 1'b1;
      r_count    <= w_count_nxt;
      r_inflight <= w_inflight_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_q[r_wr] <= i_imem_rdata;
  end

  assign o_imem_req  = w_req;
  assign o_imem_addr = r_fetch_pc;
  assign o_valid_F   = w_valid;
  assign o_pc_F      = r_deliver_pc;
  assign o_pc_four_F = r_deliver_pc + 32'd4;
  assign o_instr_F   = !w_valid ? 32'h0 : (r_count != '0) ? w_head : i_imem_rdata;

  a_no_orphan_rvalid: assert property (@(posedge i_clk) disable iff (i_rst)
    i_imem_rvalid |-> (r_inflight != '0));
endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: expected pc/instr stream is queued at reset and
// redirect, and popped as the stage delivers into IF/ID.
module tb_fetch_stage;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, stall, redir, gnt;
  logic [31:0] rpc;
  logic        req, valid;
  logic [31:0] addr, pc, pc4, instr;
  logic        m_rvalid;
  logic [31:0] m_rdata;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  mreq_t mq[$];
  exp_t  sb[$];
  int    cyc, lat;
  int    n_chk = 0, n_pass = 0, n_deliv = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RST_PC), .QDEPTH(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_redirect(redir),
    .i_redirect_pc(rpc), .o_imem_req(req), .o_imem_addr(addr),
    .i_imem_gnt(gnt), .i_imem_rvalid(m_rvalid), .i_imem_rdata(m_rdata),
    .o_valid_F(valid), .o_pc_F(pc), .o_pc_four_F(pc4), .o_instr_F(instr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  // In-order memory, fixed latency, data tagged as ~address; reset with the DUT.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_rvalid <= 1'b0;
      m_rdata  <= 32'h0;
      cyc      <= 0;
    end else begin
      cyc      <= cyc + 1;
      m_rvalid <= 1'b0;
      if (req && gnt) mq.push_back('{addr: addr, due: cyc + lat});
      if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
        m_rvalid <= 1'b1;
        m_rdata  <= ~mq[0].addr;
        void'(mq.pop_front());
      end
    end
  end

  task automatic sb_restart(input logic [31:0] start);
    logic [31:0] p;
    sb.delete();
    p = start;
    for (int i = 0; i < 64; i++) begin
      sb.push_back('{pc: p, instr: ~p});
      p = p + 32'd4;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (valid) begin
        if (sb.size() == 0) chk("sb_empty", 32'd1, 32'd0);
        else begin
          chk("pc", pc, sb[0].pc);
          chk("pc4", pc4, sb[0].pc + 32'd4);
          chk("instr", instr, sb[0].instr);
          if (sb[0].pc == 32'hFFFF_FFFC) chk("pc4_wrap", pc4, 32'h0);
          if (!stall) begin
            void'(sb.pop_front());
            n_deliv++;
          end
        end
      end else chk("instr_idle", instr, 32'h0);
    end
  end

  task automatic wait_deliv(input string tag, input int n, input int bound);
    int s, c;
    s = n_deliv;
    c = 0;
    while (n_deliv < s + n && c < bound) begin
      @(posedge clk);
      c++;
    end
    @(posedge clk); #1;
    chk(tag, 32'(n_deliv - s >= n), 32'd1);
  endtask

  initial begin
    int s, c;
    rst = 1'b1; stall = 1'b0; redir = 1'b0; rpc = 32'h0; gnt = 1'b1; lat = 1;
    sb_restart(RST_PC);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_addr", addr, RST_PC);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_pc", pc, RST_PC);
    chk("rst_pc4", pc4, RST_PC + 32'd4);
    chk("rst_instr", instr, 32'h0);
    rst = 1'b0;
    #1 chk("first_req", 32'(req), 32'd1);
    wait_deliv("stream", 12, 40);

    // Steady state: one delivery per cycle.
    s = n_deliv;
    repeat (10) @(posedge clk);
    #1 chk("throughput", 32'(n_deliv - s), 32'd10);

    // Stall: credits run out, head held, resumes without gap/duplicate.
    stall = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("stall_req", 32'(req), 32'd0);
    chk("stall_valid", 32'(valid), 32'd1);
    stall = 1'b0;
    wait_deliv("after_stall", 8, 30);

    // Random grants.
    for (int i = 0; i < 20; i++) begin
      gnt = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    gnt = 1'b1;
    wait_deliv("rand_gnt", 4, 30);

    // Redirect with two responses outstanding.
    lat = 2;
    repeat (6) @(posedge clk);
    #1;
    c = 0;
    while ((mq.size() + int'(m_rvalid)) < 2 && c < 20) begin
      @(posedge clk); #1;
      c++;
    end
    chk("two_inflight", 32'((mq.size() + int'(m_rvalid)) >= 2), 32'd1);
    redir = 1'b1; rpc = 32'h0000_0103;
    sb_restart(32'h0000_0100);
    #1 chk("redir_req", 32'(req), 32'd0);
    @(posedge clk); #1;
    redir = 1'b0;
    wait_deliv("redir_stream", 6, 30);

    // Redirect together with rvalid and stall.
    lat = 1;
    repeat (4) @(posedge clk);
    #1;
    c = 0;
    while (!m_rvalid && c < 20) begin
      @(posedge clk); #1;
      c++;
    end
    chk("rvalid_seen", 32'(m_rvalid), 32'd1);
    stall = 1'b1; redir = 1'b1; rpc = 32'h0000_0200;
    sb_restart(32'h0000_0200);
    #1 chk("redir_valid", 32'(valid), 32'd0);
    @(posedge clk); #1;
    redir = 1'b0;
    chk("q_empty", 32'(valid), 32'd0);
    stall = 1'b0;
    wait_deliv("redir2_stream", 4, 30);

    // PC wrap.
    redir = 1'b1; rpc = 32'hFFFF_FFF8;
    sb_restart(32'hFFFF_FFF8);
    @(posedge clk); #1;
    redir = 1'b0;
    wait_deliv("wrap_stream", 5, 30);

    // Asynchronous reset with a full queue.
    stall = 1'b1;
    repeat (8) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_addr", addr, RST_PC);
    chk("arst_req", 32'(req), 32'd0);
    chk("arst_instr", instr, 32'h0);
    @(posedge clk); #1;
    sb_restart(RST_PC);
    rst = 1'b0; stall = 1'b0;
    wait_deliv("restart", 6, 30);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
